// File: rtl/osyrys64_pkg.sv
// Shared types and constants for the osyrys64 core: NPU command opcodes,
// NPU dispatcher FSM states and the default NPU watchdog limit.
package osyrys64_pkg;

    typedef enum logic [1:0] {
        NPU_OP_NONE   = 2'b00,
        NPU_OP_MATMUL = 2'b01,
        NPU_OP_CONV   = 2'b10
    } npu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        WB    = 2'b11
    } npu_disp_state_t;

    localparam int NPU_TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/npu_watchdog.sv
// NPU watchdog: a down-counter that is loaded with TIMEOUT_CYCLES-1 when an
// NPU op starts and counts down while the op is outstanding. expired is high
// while the op is still outstanding and the count has reached zero, which is
// the TIMEOUT_CYCLES-th outstanding cycle.
module npu_watchdog
    import osyrys64_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = NPU_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Load on start, count down while the op is outstanding, hold at zero.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = LOAD;
        end else if (run && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = run && (count_q == '0);

endmodule

// File: rtl/npu_dispatch.sv
// NPU dispatcher: takes decoded NPU instructions, issues one command to the
// NPU, stalls the scalar pipeline until the response arrives and returns the
// result as a one-cycle register-file writeback.
// Optional feature: define NPU_TIMEOUT_EN to add a watchdog that aborts an
// op after TIMEOUT_CYCLES outstanding cycles and pulses npu_timeout.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no op in flight; stray NPU responses are accepted and dropped
// ISSUE | command presented to the NPU, waiting for npu_cmd_ready
// WAIT  | command accepted, waiting for npu_rsp_valid
// WB    | one-cycle register-file writeback (suppressed for rd=0 / flushed)
module npu_dispatch
    import osyrys64_pkg::*;
#(
    parameter int XLEN           = 64,
    parameter int TIMEOUT_CYCLES = NPU_TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic            is_npu_matrix_mul,
    input  logic            is_npu_conv,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_addr,
    input  logic            flush,
    output logic            stall,
    output logic            npu_cmd_valid,
    input  logic            npu_cmd_ready,
    output npu_op_t         npu_cmd_op,
    output logic [XLEN-1:0] npu_cmd_a,
    output logic [XLEN-1:0] npu_cmd_b,
    input  logic            npu_rsp_valid,
    output logic            npu_rsp_ready,
    input  logic [XLEN-1:0] npu_rsp_data,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            npu_timeout
);

    // The watchdog's down-counter needs at least two cycles to be meaningful.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("npu_dispatch: TIMEOUT_CYCLES must be at least 2");
    end

    npu_disp_state_t state_q, state_d;
    npu_op_t         op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            flushed_q, flushed_d;

    logic            start;
    logic            timeout_fire;

    assign start = (state_q == IDLE) && id_valid && (is_npu_matrix_mul || is_npu_conv)
                   && !flush && !rst;

`ifdef NPU_TIMEOUT_EN
    logic wd_expired;
    logic wd_run;

    assign wd_run = (state_q == ISSUE) || (state_q == WAIT);

    npu_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (start),
        .run    (wd_run),
        .expired(wd_expired)
    );

    // A handshake or flush-abandon in the terminal cycle wins over the abort.
    assign timeout_fire = wd_expired && !rst
                          && !((state_q == ISSUE) && (npu_cmd_ready || flush))
                          && !((state_q == WAIT) && npu_rsp_valid);
`else
    assign timeout_fire = 1'b0;
`endif

    // Next-state and latch-enable logic for the dispatcher FSM.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        rd_d      = rd_q;
        data_d    = data_q;
        flushed_d = flushed_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d      = is_npu_matrix_mul ? NPU_OP_MATMUL : NPU_OP_CONV;
                    a_d       = rs1_data;
                    b_d       = rs2_data;
                    rd_d      = rd_addr;
                    flushed_d = 1'b0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (npu_cmd_ready) begin
                    // Command is gone; a coincident flush only kills the writeback.
                    flushed_d = flush;
                    state_d   = WAIT;
                end else if (flush) begin
                    state_d = IDLE;
                end else if (timeout_fire) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (flush) begin
                    flushed_d = 1'b1;
                end
                if (npu_rsp_valid) begin
                    data_d  = npu_rsp_data;
                    state_d = WB;
                end else if (timeout_fire) begin
                    state_d = IDLE;
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and operand registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= NPU_OP_NONE;
            a_q       <= '0;
            b_q       <= '0;
            rd_q      <= '0;
            data_q    <= '0;
            flushed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
            flushed_q <= flushed_d;
        end
    end

    // Output decode from the registered state.
    always_comb begin
        stall         = (state_q != IDLE) || start;
        npu_cmd_valid = (state_q == ISSUE);
        npu_cmd_op    = op_q;
        npu_cmd_a     = a_q;
        npu_cmd_b     = b_q;
        npu_rsp_ready = ((state_q == IDLE) || (state_q == WAIT)) && !rst;
        wb_valid      = (state_q == WB) && (rd_q != 5'd0) && !flushed_q;
        wb_rd         = wb_valid ? rd_q : 5'd0;
        wb_data       = wb_valid ? data_q : '0;
        npu_timeout   = timeout_fire;
    end

endmodule
